digit_entry: RTL and testbench
==============================

DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-002 SHALL have ports: clear  in  1  reset, synchronous, active-high.
REQ-003 SHALL have ports: D  in  4  BCD digit from keypad encoder, valid while loadn low.
REQ-004 SHALL have ports: loadn  in  1  active-low digit-load strobe from keypad encoder.
REQ-005 SHALL have ports: tick_1hz  in  1  one-clk-wide 1 Hz countdown pulse.
REQ-006 SHALL have ports: start, stop  in  1 each  level-sampled, one-cycle-effective commands.
REQ-007 SHALL have ports: min_tens, min_ones, sec_tens, sec_ones  out  4 each  displayed time MM:SS, BCD.
REQ-008 SHALL have ports: running  out  1  high in RUN; done  out  1  high in DONE; entry_err  out  1  one-cycle pulse on rejected digit; beep  out  1  see REQ-025.

Function
REQ-009 SHALL detect a load as the first cycle loadn is sampled low after being high; a held-low loadn SHALL produce exactly one load.
REQ-010 On accepted load: min_tens<=min_ones, min_ones<=sec_tens, sec_tens<=sec_ones, sec_ones<=D, all in the same edge; digits visible one cycle after the detected edge.
REQ-011 Load with D>9 SHALL leave all digits unchanged and pulse entry_err for one cycle.
REQ-012 States: IDLE, ENTRY, RUN, PAUSE, DONE.
REQ-013 IDLE/ENTRY/DONE + accepted load -> ENTRY (DONE first zeroes all digits, then shifts in D).
REQ-014 ENTRY + start with any nonzero digit -> RUN; start with all digits zero -> stay ENTRY.
REQ-015 Loads SHALL be ignored (no shift, no entry_err) in RUN and PAUSE.
REQ-016 RUN + tick_1hz -> decrement MM:SS by one second: sec_ones 0->9 borrows sec_tens; sec_tens:sec_ones 00 -> 59 borrows minutes; min_ones 0->9 borrows min_tens.
REQ-017 Seconds entered >59 (e.g. 01:75) SHALL be counted as entered, with no normalisation: 01:75 -> 01:74 ... 01:00 -> 00:59.
REQ-018 RUN: when the decrement yields 00:00 -> DONE on the same edge; running low, done high from the next cycle.
REQ-019 RUN + stop -> PAUSE; PAUSE + start -> RUN; PAUSE + stop -> digits zeroed, IDLE.
REQ-020 Priority within one cycle: clear > stop > load > start > tick; in RUN, stop and tick together -> PAUSE with no decrement.
REQ-021 ENTRY: load and start in the same cycle -> load taken, start ignored.
REQ-022 DONE: digits stay 00:00 until a load or clear.

Reset
REQ-023 clear high SHALL, on the next edge, set state IDLE, all digits 0, running/done/entry_err/beep 0, and the loadn edge detector to "previous=high"; this SHALL apply from any state, including mid-countdown.

Configuration
REQ-024 Macro DIGIT_ENTRY_BEEP_EN selects the beep feature.
REQ-025 Defined: on entering DONE, beep SHALL go high and remain high for exactly 3 tick_1hz pulses, then low; a load or clear SHALL end it immediately. Undefined: beep tied 0, no beep counter.

Structure
REQ-026 Shared package digit_entry_pkg SHALL hold the state enumeration, BCD_MAX=9, SEC_TENS_WRAP=5, and BEEP_TICKS=3.
REQ-027 One sub-module, bcd_dec_digit, SHALL provide a single-digit decrement: inputs digit, borrow_in, wrap value; outputs next digit, borrow_out. It SHALL be instantiated four times.

Verification
REQ-028 Load sequence 1,2,3,4 -> 12:34; hold loadn low 5 cycles -> single shift only.
REQ-029 Load D=4'hB after 00:05 -> digits unchanged, entry_err one-cycle pulse.
REQ-030 From 01:00, start, one tick -> 00:59; from 00:01, one tick -> 00:00, done=1, running=0.
REQ-031 In RUN at 00:30, stop and tick in the same cycle -> PAUSE, still 00:30; start -> RUN; stop, then stop -> 00:00, IDLE.
REQ-032 Assert clear mid-countdown at 05:12 -> next cycle 00:00, IDLE, all flags 0; start with all digits zero in ENTRY -> remains ENTRY.
REQ-033 With DIGIT_ENTRY_BEEP_EN: from 00:01, tick -> beep high for 3 ticks, then low; without the macro, beep is constant 0.

Source files
------------

// File: rtl/digit_entry_pkg.sv
// Shared types and constants for the keypad digit-entry countdown timer.
package digit_entry_pkg;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned BEEP_CNT_W = 2;
  localparam int unsigned BEEP_TICKS = 3;

  localparam logic [DIGIT_W-1:0] BCD_MAX       = 4'd9;
  localparam logic [DIGIT_W-1:0] SEC_TENS_WRAP = 4'd5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/digit_entry_bcd_dec_digit.sv
// Single BCD digit decrement with borrow chaining and a per-digit wrap value.
module bcd_dec_digit
  import digit_entry_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  input  logic               borrow_in,
  input  logic [DIGIT_W-1:0] wrap,
  output logic [DIGIT_W-1:0] next_digit,
  output logic               borrow_out
);

  always_comb begin
    next_digit = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == '0) begin
        next_digit = wrap;
        borrow_out = 1'b1;
      end else begin
        next_digit = digit - DIGIT_W'(1);
      end
    end
  end

endmodule

// File: rtl/digit_entry.sv
// MM:SS keypad entry and countdown timer with run/pause/done control.
// Optional beep on completion is enabled by defining DIGIT_ENTRY_BEEP_EN.
module digit_entry
  import digit_entry_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic [DIGIT_W-1:0] D,
  input  logic               loadn,
  input  logic               tick_1hz,
  input  logic               start,
  input  logic               stop,
  output logic [DIGIT_W-1:0] min_tens,
  output logic [DIGIT_W-1:0] min_ones,
  output logic [DIGIT_W-1:0] sec_tens,
  output logic [DIGIT_W-1:0] sec_ones,
  output logic               running,
  output logic               done,
  output logic               entry_err,
  output logic               beep
);

  state_t state;
  logic   loadn_prev;

  logic load_edge;
  logic load_window;
  logic load_ok;
  logic load_bad;
  logic digits_zero;
  logic dec_zero;

  logic [DIGIT_W-1:0] so_dec, st_dec, mo_dec, mt_dec;
  logic               b_so, b_st, b_mo;
  logic               dec_unused_borrow;

  // Countdown chain: seconds ones always decrements, borrows ripple upward.
  bcd_dec_digit u_sec_ones (
    .digit(sec_ones), .borrow_in(1'b1), .wrap(BCD_MAX),
    .next_digit(so_dec), .borrow_out(b_so)
  );
  bcd_dec_digit u_sec_tens (
    .digit(sec_tens), .borrow_in(b_so), .wrap(SEC_TENS_WRAP),
    .next_digit(st_dec), .borrow_out(b_st)
  );
  bcd_dec_digit u_min_ones (
    .digit(min_ones), .borrow_in(b_st), .wrap(BCD_MAX),
    .next_digit(mo_dec), .borrow_out(b_mo)
  );
  bcd_dec_digit u_min_tens (
    .digit(min_tens), .borrow_in(b_mo), .wrap(BCD_MAX),
    .next_digit(mt_dec), .borrow_out(dec_unused_borrow)
  );

  always_comb begin
    load_edge   = loadn_prev & ~loadn;
    load_window = (state == ST_IDLE) || (state == ST_ENTRY) || (state == ST_DONE);
    load_ok     = load_edge & load_window & is_bcd(D);
    load_bad    = load_edge & load_window & ~is_bcd(D);
    digits_zero = {min_tens, min_ones, sec_tens, sec_ones} == 16'd0;
    dec_zero    = {mt_dec, mo_dec, st_dec, so_dec} == 16'd0;
  end

  // Control FSM with registered digits and status flags.
  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= ST_IDLE;
      loadn_prev <= 1'b1;
      min_tens   <= '0;
      min_ones   <= '0;
      sec_tens   <= '0;
      sec_ones   <= '0;
      running    <= 1'b0;
      done       <= 1'b0;
      entry_err  <= 1'b0;
    end else begin
      loadn_prev <= loadn;
      entry_err  <= 1'b0;
      case (state)
        ST_IDLE, ST_ENTRY: begin
          if (load_ok) begin
            min_tens <= min_ones;
            min_ones <= sec_tens;
            sec_tens <= sec_ones;
            sec_ones <= D;
            state    <= ST_ENTRY;
          end else if (load_bad) begin
            entry_err <= 1'b1;
          end else if ((state == ST_ENTRY) && start && !digits_zero) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        ST_DONE: begin
          if (load_ok) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= D;
            state    <= ST_ENTRY;
            done     <= 1'b0;
          end else if (load_bad) begin
            entry_err <= 1'b1;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state   <= ST_PAUSE;
            running <= 1'b0;
          end else if (tick_1hz) begin
            min_tens <= mt_dec;
            min_ones <= mo_dec;
            sec_tens <= st_dec;
            sec_ones <= so_dec;
            if (dec_zero) begin
              state   <= ST_DONE;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        ST_PAUSE: begin
          if (stop) begin
            min_tens <= '0;
            min_ones <= '0;
            sec_tens <= '0;
            sec_ones <= '0;
            state    <= ST_IDLE;
          end else if (start) begin
            state   <= ST_RUN;
            running <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

`ifdef DIGIT_ENTRY_BEEP_EN
  logic                  enter_done;
  logic [BEEP_CNT_W-1:0] beep_cnt;

  always_comb begin
    enter_done = (state == ST_RUN) && !stop && tick_1hz && dec_zero;
  end

  // Beep holds for a fixed number of ticks after completion; a load cuts it short.
  always_ff @(posedge clk) begin
    if (clear) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if (enter_done) begin
      beep     <= 1'b1;
      beep_cnt <= '0;
    end else if (beep && (state == ST_DONE) && load_ok) begin
      beep     <= 1'b0;
      beep_cnt <= '0;
    end else if (beep && tick_1hz) begin
      if (beep_cnt == BEEP_CNT_W'(BEEP_TICKS - 1)) begin
        beep     <= 1'b0;
        beep_cnt <= '0;
      end else begin
        beep_cnt <= beep_cnt + BEEP_CNT_W'(1);
      end
    end
  end
`else
  assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_digit_entry.sv
// Scoreboard bench for digit_entry: driver queues expected snapshots, monitor compares.
module tb_digit_entry;

  logic       clk = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] D = 4'd0;
  logic       loadn = 1'b1;
  logic       tick_1hz = 1'b0;
  logic       start = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       running, done, entry_err, beep;

`ifdef DIGIT_ENTRY_BEEP_EN
  localparam bit BEEP_ON = 1'b1;
`else
  localparam bit BEEP_ON = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [15:0] dig;
    logic       run;
    logic       dn;
    logic       err;
    logic       bp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   stim_done = 1'b0;

  digit_entry dut (
    .clk(clk), .clear(clear), .D(D), .loadn(loadn), .tick_1hz(tick_1hz),
    .start(start), .stop(stop),
    .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens), .sec_ones(sec_ones),
    .running(running), .done(done), .entry_err(entry_err), .beep(beep)
  );

  always #5 clk = ~clk;

  // Monitor: compare every queued expectation at the falling edge.
  always @(negedge clk) begin
    exp_t e;
    logic [19:0] act, req;
    while (q.size() > 0) begin
      e   = q.pop_front();
      act = {min_tens, min_ones, sec_tens, sec_ones, running, done, entry_err, beep};
      req = {e.dig, e.run, e.dn, e.err, e.bp};
      checks++;
      if (act !== req) begin
        errors++;
        $display("FAIL %s: got digits=%h run=%b done=%b err=%b beep=%b, want digits=%h run=%b done=%b err=%b beep=%b",
                 e.name, act[19:4], act[3], act[2], act[1], act[0],
                 e.dig, e.run, e.dn, e.err, e.bp);
      end
    end
  end

  task automatic cyc(input logic ld_n, input logic [3:0] d, input logic s,
                     input logic p, input logic t, input logic c);
    loadn = ld_n; D = d; start = s; stop = p; tick_1hz = t; clear = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic ld(input logic [3:0] d);
    cyc(1'b0, d, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic do_clear();
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic do_start();
    cyc(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_stop();
    cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_tick();
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic chk(input string name, input logic [15:0] dig, input logic run,
                     input logic dn, input logic err, input logic bp);
    exp_t e;
    e.name = name; e.dig = dig; e.run = run; e.dn = dn; e.err = err; e.bp = bp & BEEP_ON;
    q.push_back(e);
  endtask

  initial begin
    do_clear();
    chk("reset", 16'h0000, 0, 0, 0, 0);

    // Shift-in entry and held-low strobe
    ld(4'd1);  chk("load_1", 16'h0001, 0, 0, 0, 0);
    ld(4'd2); ld(4'd3); ld(4'd4);
    chk("load_1234", 16'h1234, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) cyc(1'b0, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("held_loadn_single_shift", 16'h2345, 0, 0, 0, 0);

    // Rejected digit
    do_clear();
    ld(4'd0); ld(4'd0); ld(4'd0); ld(4'd5);
    chk("load_0005", 16'h0005, 0, 0, 0, 0);
    cyc(1'b0, 4'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("bad_digit_err", 16'h0005, 0, 0, 1, 0);
    idle();
    chk("bad_digit_err_pulse_end", 16'h0005, 0, 0, 0, 0);

    // Start rules and minute borrow
    do_clear();
    do_start();
    chk("idle_start_ignored", 16'h0000, 0, 0, 0, 0);
    ld(4'd0);
    do_start();
    chk("entry_zero_start_stays", 16'h0000, 0, 0, 0, 0);
    ld(4'd1); ld(4'd0); ld(4'd0);
    chk("load_0100", 16'h0100, 0, 0, 0, 0);
    do_start();
    chk("start_run", 16'h0100, 1, 0, 0, 0);
    do_tick();
    chk("tick_0100_to_0059", 16'h0059, 1, 0, 0, 0);
    cyc(1'b0, 4'd3, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("load_ignored_in_run", 16'h0059, 1, 0, 0, 0);
    idle();

    // Unnormalised seconds and min_ones borrow
    do_clear();
    ld(4'd0); ld(4'd1); ld(4'd7); ld(4'd5);
    do_start();
    do_tick();
    chk("tick_0175_to_0174", 16'h0174, 1, 0, 0, 0);
    do_clear();
    ld(4'd1); ld(4'd0); ld(4'd0); ld(4'd0);
    do_start();
    do_tick();
    chk("tick_1000_to_0959", 16'h0959, 1, 0, 0, 0);

    // Reaching zero, done hold, beep window, reload from done
    do_clear();
    ld(4'd1);
    do_start();
    do_tick();
    chk("tick_to_done", 16'h0000, 0, 1, 0, 1);
    do_tick();
    chk("done_tick1", 16'h0000, 0, 1, 0, 1);
    do_tick();
    chk("done_tick2", 16'h0000, 0, 1, 0, 1);
    do_tick();
    chk("done_tick3_beep_off", 16'h0000, 0, 1, 0, 0);
    do_start();
    chk("done_start_ignored", 16'h0000, 0, 1, 0, 0);
    ld(4'd7);
    chk("done_reload", 16'h0007, 0, 0, 0, 0);
    cyc(1'b0, 4'd8, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("load_beats_start", 16'h0078, 0, 0, 0, 0);
    do_start();
    chk("start_after_reload", 16'h0078, 1, 0, 0, 0);

    // Pause/resume/abort
    do_clear();
    ld(4'd3); ld(4'd0);
    do_start();
    cyc(1'b1, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("stop_tick_pause_no_dec", 16'h0030, 0, 0, 0, 0);
    do_tick();
    chk("pause_tick_ignored", 16'h0030, 0, 0, 0, 0);
    do_start();
    chk("pause_resume", 16'h0030, 1, 0, 0, 0);
    do_stop();
    chk("pause_again", 16'h0030, 0, 0, 0, 0);
    do_stop();
    chk("pause_stop_abort", 16'h0000, 0, 0, 0, 0);
    do_start();
    chk("abort_idle_start_ignored", 16'h0000, 0, 0, 0, 0);

    // Clear mid-countdown
    do_clear();
    ld(4'd5); ld(4'd1); ld(4'd2);
    do_start();
    chk("run_0512", 16'h0512, 1, 0, 0, 0);
    cyc(1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("clear_mid_countdown", 16'h0000, 0, 0, 0, 0);
    ld(4'd0);
    do_start();
    chk("entry_zero_start_after_clear", 16'h0000, 0, 0, 0, 0);

    idle();
    stim_done = 1'b1;
  end

  initial begin
    int budget;
    budget = 0;
    while (!stim_done && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    @(negedge clk);
    @(negedge clk);
    if (!stim_done || q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL completion: stim_done=%0b pending=%0d, want stim_done=1 pending=0",
               stim_done, q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
